fetch_unit: RTL and testbench

- PC register and instruction-fetch sequencer; sits directly upstream of the next-PC calculator.
- Drives the current `pc` into the calculator and fetches the instruction word at `pc` from instruction memory over a req/ack handshake.
- Presents the fetched instruction to decode with a valid/accept handshake.
- On accept, loads the calculator's `next_pc` into `pc` and starts the next fetch.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch sequencer: req/ack fetch from imem, valid/accept handoff to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned next_pc traps into a sticky error state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      next_pc,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_accept,
  input  logic             stall,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             align_err
);

  typedef enum logic [1:0] {StIdle, StReq, StValid, StErr} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic             accept, fetch_done, misaligned;

  assign accept     = (state_q == StValid) && instr_accept && !stall;
  assign fetch_done = (state_q == StReq) && imem_ack;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // State register plus the registered datapath and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      retire_q      <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retire_q      <= retire_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StReq;
      StReq:   if (imem_ack) state_d = StValid;
      StValid: if (accept) state_d = misaligned ? StErr : StReq;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // Handshake flags are registered from the next state so they come straight off flops.
  always_comb begin
    imem_req_d    = (state_d == StReq);
    instr_valid_d = (state_d == StValid);
    pc_d          = accept ? next_pc : pc_q;
    instr_d       = fetch_done ? imem_rdata : instr_q;
    retire_d      = retire_q + {{(CNT_W-1){1'b0}}, accept};
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err_q <= 1'b0;
    end else if (state_d == StErr) begin
      align_err_q <= 1'b1;
    end
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  assign pc          = pc_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a driver queues expected fetch PCs, a monitor
// pops and checks them as the DUT requests memory and hands instructions to decode.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned CNT_W    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      next_pc, pc, imem_addr, imem_rdata, instr;
  logic             imem_req, imem_ack, instr_valid, instr_accept, stall, align_err;
  logic [CNT_W-1:0] retire_cnt;

  fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .stall        (stall),
    .retire_cnt   (retire_cnt),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: PCs the DUT must fetch, in order, and instruction words it must present.
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  bit resp_en   = 1'b0;
  bit force_ack = 1'b0;
  bit mon_en    = 1'b0;
  int drv_mode  = 0;  // 0: idle, 1: random traffic, 2: one misaligned accept
  int cyc       = 0;
  int model_retire = 0;
  bit prev_hs = 1'b0, prev_acc = 1'b0, prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got nothing expected an event (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h3C01_1234;
    return {a[15:0] ^ 16'hA5C3, ~a[31:16]} + 32'h0101_0101;
  endfunction

  // Memory responder: random 0..3 wait states, spurious acks while no request is open.
  int wait_left = 0;
  initial begin : responder
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (!resp_en) begin
        imem_ack = force_ack;
      end else if (imem_req) begin
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_left  = $urandom_range(0, 3);
        end else begin
          wait_left--;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        imem_ack = 1'b1;
      end
    end
  end

  // Decode-side driver; decides every accept and pushes the PC the DUT must fetch next.
  logic [31:0] drv_pc = RESET_PC;
  int  n_acc = 0, stall_hold = 0;
  bit  held = 1'b0, drop = 1'b0, done_mis = 1'b0;
  initial begin : driver
    instr_accept = 1'b0;
    stall        = 1'b0;
    next_pc      = '0;
    forever begin
      @(posedge clk);
      #1;
      instr_accept = 1'b0;
      stall        = 1'b0;
      next_pc      = $urandom;
      if (drv_mode == 1) begin
        if (instr_valid && !held && (n_acc % 8 == 3)) begin
          stall_hold = 5;
          held       = 1'b1;
        end
        if (instr_valid && stall_hold > 0) begin
          instr_accept = 1'b1;
          stall        = 1'b1;
          stall_hold--;
          if (stall_hold == 0) drop = 1'b1;
        end else if (instr_valid && drop) begin
          instr_accept = 1'b1;
          drop         = 1'b0;
        end else begin
          instr_accept = ($urandom_range(0, 2) != 0);
          stall        = ($urandom_range(0, 3) == 0);
        end
        if (instr_valid && instr_accept && !stall) begin
          if (n_acc == 3) next_pc = 32'h0000_3100;
          else if (n_acc > 3 && $urandom_range(0, 3) == 0) next_pc = $urandom & 32'hFFFF_FFFC;
          else next_pc = drv_pc + 32'd4;
          exp_pc_q.push_back(next_pc);
          drv_pc = next_pc;
          n_acc++;
          held = 1'b0;
        end
      end else if (drv_mode == 2) begin
        if (instr_valid && !done_mis) begin
          instr_accept = 1'b1;
          next_pc      = 32'h0000_3002;
          done_mis     = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT fetches or presents an instruction.
  logic [31:0] mon_pc = RESET_PC, mon_instr = '0, e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        if (cyc == 1) check1("idle_no_req", imem_req, 1'b0);
        if (cyc == 2) check1("first_req_latency", imem_req, 1'b1);
        check1("align_err_clear", align_err, 1'b0);
        if (prev_hs) begin
          check1("ack_to_valid", instr_valid, 1'b1);
          check1("req_drop", imem_req, 1'b0);
        end
        if (prev_acc) begin
          check1("accept_to_req", imem_req, 1'b1);
          check1("valid_drop", instr_valid, 1'b0);
        end
        if (imem_req) begin
          if (exp_pc_q.size() == 0) begin
            fail_now("unexpected_req");
          end else begin
            e = exp_pc_q[0];
            check("req_pc", pc, e);
            check("req_addr", imem_addr, {e[31:2], 2'b00});
            if (imem_ack) begin
              void'(exp_pc_q.pop_front());
              exp_instr_q.push_back(mem_word({e[31:2], 2'b00}));
              mon_pc = e;
            end
          end
        end
        if (instr_valid) begin
          if (!prev_valid) begin
            if (exp_instr_q.size() == 0) fail_now("unexpected_valid");
            else mon_instr = exp_instr_q.pop_front();
          end
          check("valid_instr", instr, mon_instr);
          check("valid_pc", pc, mon_pc);
          if (instr_accept && !stall) begin
            check("retire_cnt", retire_cnt, model_retire);
            model_retire++;
          end
        end
        prev_hs    = imem_req && imem_ack;
        prev_acc   = instr_valid && instr_accept && !stall;
        prev_valid = instr_valid;
      end
    end
  end

  bit found;
  initial begin : main
    reset = 1'b1;
    exp_pc_q.push_back(RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RESET_PC);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_retire", retire_cnt, 32'h0);
    check1("rst_align", align_err, 1'b0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cyc      = 0;
    mon_en   = 1'b1;
    resp_en  = 1'b1;
    drv_mode = 1;

    repeat (3000) @(posedge clk);
    @(negedge clk);
    #1;
    check("final_retire", retire_cnt + {31'b0, prev_acc}, model_retire);
    check1("progress", model_retire >= 100, 1'b1);
    mon_en  = 1'b0;
    resp_en = 1'b0;

    // Reset while a request is open and unanswered.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #2;
      if (imem_req) found = 1'b1;
    end
    if (!found) fail_now("open_req_for_reset");
    #1;
    reset = 1'b1;
    #1;
    check1("midreq_req_drop", imem_req, 1'b0);
    check("midreq_pc", pc, RESET_PC);
    check1("midreq_valid", instr_valid, 1'b0);
    check("midreq_retire", retire_cnt, 32'h0);
    drv_mode  = 0;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check1("late_ack_idle_req", imem_req, 1'b0);
    @(negedge clk);
    check1("late_ack_req", imem_req, 1'b1);
    check("late_ack_addr", imem_addr, RESET_PC);
    check1("late_ack_valid", instr_valid, 1'b0);
    check("late_ack_instr", instr, 32'h0);
    @(negedge clk);
    check1("late_ack_ignored", imem_req, 1'b1);
    check1("late_ack_no_valid", instr_valid, 1'b0);

    // Misaligned redirect.
    resp_en  = 1'b1;
    drv_mode = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    check1("mis_fetch_valid", found, 1'b1);
    check("mis_fetch_instr", instr, 32'h3C01_1234);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!instr_valid) found = 1'b1;
    end
    check1("mis_accepted", found, 1'b1);
    check("mis_pc", pc, 32'h0000_3002);
    check("mis_retire", retire_cnt, 32'h1);
`ifdef FETCH_ALIGN_CHECK_EN
    check1("mis_align_err", align_err, 1'b1);
    check1("mis_no_req", imem_req, 1'b0);
    repeat (5) @(negedge clk);
    check1("mis_err_sticky", align_err, 1'b1);
    check1("mis_err_no_req", imem_req, 1'b0);
    check1("mis_err_no_valid", instr_valid, 1'b0);
`else
    check1("mis_align_err", align_err, 1'b0);
    check1("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h0000_3000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
